rggen_adapter_common_ex: RTL and testbench

Next-generation common bus adapter between a protocol-specific bus front end (rggen_bus_if) and an array of register blocks (rggen_register_if).
- Adds an explicit access state machine.
- Adds an optional registered response slice for timing closure.
- Adds an access watchdog that terminates hung accesses with an error.
- Drop-in successor for the existing common adapter inside every protocol adapter (APB/AXI4-Lite/Wishbone/Avalon).

---
 rtl/rggen_rtl_pkg.sv | 19 +
 rtl/rggen_bus_if.sv | 26 ++
 rtl/rggen_register_if.sv | 27 ++
 rtl/rggen_adapter_timer.sv | 37 +++
 rtl/rggen_mux.sv | 16 +
 rtl/rggen_adapter_common_ex.sv | 150 +++++++++++++++
 tb/tb_rggen_adapter_common_ex.sv | 365 ++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types and constants for the rggen bus adapters.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } rggen_adapter_state;

    localparam int RGGEN_ADAPTER_TIMER_WIDTH = 16;

endpackage

// File: rtl/rggen_bus_if.sv
// Protocol-neutral request/response bus between a front end and the common adapter.
interface rggen_bus_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_register_if.sv
// Per-register-block request broadcast and response channel.
interface rggen_register_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    logic                     active;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport host (
        output valid, address, write, write_data, strobe,
        input  ready, active, status, read_data
    );

    modport register (
        input  valid, address, write, write_data, strobe,
        output ready, active, status, read_data
    );
endinterface

// File: rtl/rggen_adapter_timer.sv
// Access watchdog counter: clear on BUSY entry, count while enabled, flag at TIMEOUT_CYCLES-1.
module rggen_adapter_timer
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = RGGEN_ADAPTER_TIMER_WIDTH;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == LIMIT);
endmodule

// File: rtl/rggen_mux.sv
// One-hot AND-OR multiplexer.
module rggen_mux #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned ENTRIES = 2
)(
    input  logic [ENTRIES-1:0]            i_select,
    input  logic [ENTRIES-1:0][WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]              o_data
);
    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < ENTRIES; ++i) begin
            o_data = o_data | (i_data[i] & {WIDTH{i_select[i]}});
        end
    end
endmodule

// File: rtl/rggen_adapter_common_ex.sv
// Common bus adapter with access FSM, optional response slice and optional watchdog.
// Watchdog is built only when RGGEN_ADAPTER_TIMEOUT_EN is defined.
module rggen_adapter_common_ex
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH         = 32,
    parameter int unsigned          REGISTERS         = 1,
    parameter bit                   ERROR_STATUS      = 1'b0,
    parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0,
    parameter bit                   RESPONSE_SLICE    = 1'b0,
    parameter int unsigned          TIMEOUT_CYCLES    = 256
)(
    input  logic           i_clk,
    input  logic           i_rst_n,
    rggen_bus_if.slave     bus_if,
    rggen_register_if.host register_if[REGISTERS]
);
    localparam rggen_status DEFAULT_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

    if ((REGISTERS < 1) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
        $error("rggen_adapter_common_ex: REGISTERS or TIMEOUT_CYCLES out of range");
    end

    rggen_adapter_state                  state_q;
    rggen_adapter_state                  state_d;
    logic                                request;
    logic                                in_access;
    logic                                any_ready;
    logic                                complete;
    logic                                timeout;
    logic                                timer_expired;
    logic [REGISTERS-1:0]                reg_ready;
    logic [REGISTERS-1:0]                reg_active;
    logic [REGISTERS-1:0][1:0]           reg_status;
    logic [REGISTERS-1:0][BUS_WIDTH-1:0] reg_read_data;
    logic [1:0]                          mux_status;
    logic [BUS_WIDTH-1:0]                mux_read_data;
    rggen_status                         resp_status;
    logic [BUS_WIDTH-1:0]                resp_read_data;

    for (genvar i = 0; i < REGISTERS; ++i) begin : g_register
        assign register_if[i].valid      = request;
        assign register_if[i].address    = bus_if.address;
        assign register_if[i].write      = bus_if.write;
        assign register_if[i].write_data = bus_if.write_data;
        assign register_if[i].strobe     = bus_if.strobe;
        assign reg_ready[i]              = register_if[i].ready;
        assign reg_active[i]             = register_if[i].active;
        assign reg_status[i]             = register_if[i].status;
        assign reg_read_data[i]          = register_if[i].read_data;
    end

    rggen_mux #(
        .WIDTH   (2),
        .ENTRIES (REGISTERS)
    ) u_status_mux (
        .i_select (reg_ready),
        .i_data   (reg_status),
        .o_data   (mux_status)
    );

    rggen_mux #(
        .WIDTH   (BUS_WIDTH),
        .ENTRIES (REGISTERS)
    ) u_read_data_mux (
        .i_select (reg_ready),
        .i_data   (reg_read_data),
        .o_data   (mux_read_data)
    );

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    rggen_adapter_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (request && !complete),
        .i_enable  ((state_q == BUSY) && !complete),
        .o_expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // Completion priority: register ready, then decode miss, then watchdog.
    always_comb begin
        request        = bus_if.valid && (state_q == IDLE);
        in_access      = request || (state_q == BUSY);
        any_ready      = |reg_ready;
        timeout        = (state_q == BUSY) && !any_ready && timer_expired;
        complete       = in_access && (any_ready || !(|reg_active) || timeout);
        resp_status    = any_ready ? rggen_status'(mux_status)
                                   : (timeout ? RGGEN_SLAVE_ERROR : DEFAULT_STATUS);
        resp_read_data = any_ready ? mux_read_data : DEFAULT_READ_DATA;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (!complete) begin
                        state_d = BUSY;
                    end else if (RESPONSE_SLICE) begin
                        state_d = RESPOND;
                    end
                end
            end
            BUSY: begin
                if (complete) begin
                    state_d = RESPONSE_SLICE ? RESPOND : IDLE;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    if (RESPONSE_SLICE) begin : g_slice
        logic                 ready_q;
        rggen_status          status_q;
        logic [BUS_WIDTH-1:0] read_data_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                ready_q     <= 1'b0;
                status_q    <= RGGEN_OKAY;
                read_data_q <= '0;
            end else begin
                ready_q     <= complete;
                status_q    <= complete ? resp_status : RGGEN_OKAY;
                read_data_q <= complete ? resp_read_data : '0;
            end
        end

        assign bus_if.ready     = ready_q;
        assign bus_if.status    = status_q;
        assign bus_if.read_data = read_data_q;
    end else begin : g_no_slice
        assign bus_if.ready     = complete;
        assign bus_if.status    = complete ? resp_status : RGGEN_OKAY;
        assign bus_if.read_data = complete ? resp_read_data : '0;
    end
endmodule

// File: tb/tb_rggen_adapter_common_ex.sv
// Bench for rggen_adapter_common_ex: DUT 0 is unsliced with error status, DUT 1 is sliced.
module tb_rggen_adapter_common_ex;
    import rggen_rtl_pkg::*;

    localparam int NDUT    = 2;
    localparam int NREG    = 4;
    localparam int AW      = 8;
    localparam int BW      = 32;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = -1;
    localparam logic [BW-1:0] DEF0 = 32'hFFFF_FFFF;
    localparam logic [BW-1:0] DEF1 = 32'hA5A5_0000;

    typedef struct {
        logic [1:0]    status;
        logic [BW-1:0] data;
        int            lat;
    } exp_t;

    exp_t exp_q[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NDUT-1:0]                    drv_valid = '0;
    logic [NDUT-1:0]                    drv_write = '0;
    logic [NDUT-1:0][AW-1:0]            drv_addr  = '0;
    logic [NDUT-1:0][BW-1:0]            drv_wdata = '0;
    logic [NDUT-1:0]                    obs_ready;
    logic [NDUT-1:0][1:0]               obs_status;
    logic [NDUT-1:0][BW-1:0]            obs_data;
    logic [NDUT-1:0][BW-1:0]            obs_wdata;
    logic [NDUT-1:0]                    obs_wr;
    logic [NDUT-1:0][NREG-1:0]          obs_reg_valid;
    logic [NDUT-1:0][NREG-1:0][7:0]     pulse_cnt;
    logic                               cnt_clr = 1'b0;

    int            cfg_lat   [NDUT][NREG];
    logic [BW-1:0] cfg_data  [NDUT][NREG];
    logic [1:0]    cfg_status[NDUT][NREG];
    logic          cfg_force [NDUT][NREG];

    logic tmr_clear   = 1'b0;
    logic tmr_enable  = 1'b0;
    logic tmr_expired;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();
        rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) reg_if [NREG] ();

        assign bus_if.valid      = drv_valid[d];
        assign bus_if.address    = drv_addr[d];
        assign bus_if.write      = drv_write[d];
        assign bus_if.write_data = drv_wdata[d];
        assign bus_if.strobe     = '1;
        assign obs_ready[d]      = bus_if.ready;
        assign obs_status[d]     = bus_if.status;
        assign obs_data[d]       = bus_if.read_data;
        assign obs_wdata[d]      = reg_if[2].write_data;
        assign obs_wr[d]         = reg_if[2].write;

        rggen_adapter_common_ex #(
            .BUS_WIDTH         (BW),
            .REGISTERS         (NREG),
            .ERROR_STATUS      (d == 0),
            .DEFAULT_READ_DATA ((d == 0) ? DEF0 : DEF1),
            .RESPONSE_SLICE    (d == 1),
            .TIMEOUT_CYCLES    (TIMEOUT)
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .bus_if      (bus_if),
            .register_if (reg_if)
        );

        // Register block model: channel c decodes address c*4, answers cfg_lat cycles after valid.
        for (genvar c = 0; c < NREG; c++) begin : g_reg
            int         rem;
            logic [7:0] pulses;
            logic       hit;

            assign hit                 = (reg_if[c].address == AW'(c * 4));
            assign reg_if[c].active    = hit;
            assign reg_if[c].ready     = (hit && ((reg_if[c].valid && (cfg_lat[d][c] == 0))
                                                  || (rem == 1))) || cfg_force[d][c];
            assign reg_if[c].status    = rggen_status'(cfg_status[d][c]);
            assign reg_if[c].read_data = cfg_data[d][c];
            assign obs_reg_valid[d][c] = reg_if[c].valid;
            assign pulse_cnt[d][c]     = pulses;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem    <= 0;
                    pulses <= '0;
                end else begin
                    if (reg_if[c].valid && (cfg_lat[d][c] > 0)) rem <= cfg_lat[d][c];
                    else if (rem > 0) rem <= rem - 1;
                    if (cnt_clr) pulses <= '0;
                    else if (reg_if[c].valid) pulses <= pulses + 8'd1;
                end
            end
        end
    end

    rggen_adapter_timer #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) u_tmr (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clear   (tmr_clear),
        .i_enable  (tmr_enable),
        .o_expired (tmr_expired)
    );

    // Called just after a posedge; returns just after the posedge following bus ready.
    task automatic access(input string name, input int d, input logic [AW-1:0] addr,
                          input logic wr, input logic [BW-1:0] wdata, input logic [1:0] e_status,
                          input logic [BW-1:0] e_data, input int e_lat);
        exp_t e;
        exp_t g;
        int   lat;
        bit   got;
        e.status = e_status;
        e.data   = e_data;
        e.lat    = e_lat;
        exp_q.push_back(e);
        drv_addr[d]  = addr;
        drv_write[d] = wr;
        drv_wdata[d] = wdata;
        drv_valid[d] = 1'b1;
        lat = 0;
        got = 0;
        while (!got && (lat < 40)) begin
            @(negedge clk);
            if (obs_ready[d]) got = 1;
            else lat++;
        end
        g = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no bus ready within %0d cycles, required at cycle %0d",
                     name, lat, g.lat);
        end else begin
            if (lat !== g.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, g.lat);
            end
            checks++;
            if (obs_status[d] !== g.status) begin
                errors++;
                $display("FAIL %s status: got %0d required %0d", name, obs_status[d], g.status);
            end
            checks++;
            if (obs_data[d] !== g.data) begin
                errors++;
                $display("FAIL %s read_data: got %h required %h", name, obs_data[d], g.data);
            end
        end
        @(posedge clk);
        #1;
        drv_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obs_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset ready dut%0d: got %b required 0", d, obs_ready[d]);
            end
            checks++;
            if (obs_status[d] !== RGGEN_OKAY) begin
                errors++;
                $display("FAIL reset status dut%0d: got %0d required 0", d, obs_status[d]);
            end
            checks++;
            if (obs_data[d] !== '0) begin
                errors++;
                $display("FAIL reset read_data dut%0d: got %h required 0", d, obs_data[d]);
            end
        end
        checks++;
        if (obs_reg_valid !== '0) begin
            errors++;
            $display("FAIL reset register valid: got %b required 0", obs_reg_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_wait();
        cfg_lat[0][2]  = 0;
        cfg_data[0][2] = 32'h0000_C0DE;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        access("zero_wait", 0, 8'h08, 1'b1, 32'hDEAD_BEEF, RGGEN_OKAY, 32'h0000_C0DE, 0);
        for (int c = 0; c < NREG; c++) begin
            checks++;
            if (pulse_cnt[0][c] !== 8'd1) begin
                errors++;
                $display("FAIL zero_wait pulses ch%0d: got %0d required 1", c, pulse_cnt[0][c]);
            end
        end
        checks++;
        if ((obs_wdata[0] !== 32'hDEAD_BEEF) || (obs_wr[0] !== 1'b1)) begin
            errors++;
            $display("FAIL zero_wait passthrough: got %h/%b required deadbeef/1",
                     obs_wdata[0], obs_wr[0]);
        end
    endtask

    task automatic test_slice_read();
        cfg_lat[1][1]  = 3;
        cfg_data[1][1] = 32'h0000_1234;
        access("slice_read", 1, 8'h04, 1'b0, '0, RGGEN_OKAY, 32'h0000_1234, 4);
        @(negedge clk);
        checks++;
        if ((obs_ready[1] !== 1'b0) || (obs_data[1] !== '0)) begin
            errors++;
            $display("FAIL slice_read one_cycle: got ready=%b data=%h required 0/0",
                     obs_ready[1], obs_data[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_unmapped();
        access("unmapped_err", 0, 8'h40, 1'b0, '0, RGGEN_SLAVE_ERROR, DEF0, 0);
        access("unmapped_okay", 1, 8'h40, 1'b0, '0, RGGEN_OKAY, DEF1, 1);
    endtask

    task automatic test_back_to_back();
        cfg_lat[0][0]    = 2;
        cfg_data[0][0]   = 32'h1111_0000;
        cfg_lat[0][3]    = 1;
        cfg_data[0][3]   = 32'h3333_0000;
        cfg_status[0][3] = RGGEN_EXOKAY;
        cfg_lat[1][0]    = 2;
        cfg_data[1][0]   = 32'h1010_0000;
        cfg_lat[1][3]    = 1;
        cfg_data[1][3]   = 32'h3030_0000;
        access("b2b_a", 0, 8'h00, 1'b0, '0, RGGEN_OKAY, 32'h1111_0000, 2);
        access("b2b_b", 0, 8'h0C, 1'b1, 32'h0000_00AA, RGGEN_EXOKAY, 32'h3333_0000, 1);
        access("b2b_c", 1, 8'h0C, 1'b0, '0, RGGEN_OKAY, 32'h3030_0000, 2);
        access("b2b_d", 1, 8'h00, 1'b0, '0, RGGEN_OKAY, 32'h1010_0000, 3);
    endtask

    task automatic test_reset_mid_busy();
        cfg_lat[1][0] = NEVER;
        drv_addr[1]   = 8'h00;
        drv_write[1]  = 1'b0;
        drv_valid[1]  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n        = 1'b0;
        drv_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ((obs_ready[1] !== 1'b0) || (obs_reg_valid[1] !== '0)) begin
            errors++;
            $display("FAIL mid_reset outputs: got ready=%b valid=%b required 0/0",
                     obs_ready[1], obs_reg_valid[1]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset after release: got ready=%b required 0", obs_ready[1]);
        end
        cfg_lat[1][0]  = 1;
        cfg_data[1][0] = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        access("after_reset", 1, 8'h00, 1'b0, '0, RGGEN_OKAY, 32'h5A5A_5A5A, 2);
    endtask

    task automatic test_timer();
        tmr_clear = 1'b1;
        @(posedge clk);
        #1;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            checks++;
            if (tmr_expired !== (k == TIMEOUT - 1)) begin
                errors++;
                $display("FAIL timer expired at count %0d: got %b required %b",
                         k, tmr_expired, (k == TIMEOUT - 1));
            end
        end
        @(posedge clk);
        #1;
        tmr_enable = 1'b0;
    endtask

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    task automatic test_timeout();
        cfg_lat[0][1]  = NEVER;
        cfg_data[0][1] = 32'h7777_7777;
        access("timeout", 0, 8'h04, 1'b0, '0, RGGEN_SLAVE_ERROR, DEF0, TIMEOUT);
        cfg_force[0][1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL late_ready: got ready=%b required 0", obs_ready[0]);
            end
        end
        @(posedge clk);
        #1;
        cfg_force[0][1] = 1'b0;
        cfg_lat[0][1]   = TIMEOUT;
        @(posedge clk);
        #1;
        access("ready_on_expiry", 0, 8'h04, 1'b0, '0, RGGEN_OKAY, 32'h7777_7777, TIMEOUT);
    endtask
`endif

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NREG; c++) begin
                cfg_lat[d][c]    = NEVER;
                cfg_data[d][c]   = 32'h0BAD_0000 | BW'(c);
                cfg_status[d][c] = RGGEN_OKAY;
                cfg_force[d][c]  = 1'b0;
            end
        end
        #1;
        test_reset();
        test_zero_wait();
        test_slice_read();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_busy();
        test_timer();
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
